mat_rx_assembler: RTL and testbench
===================================

Name: mat_rx_assembler

Overview:
- Receive-side counterpart of the matrix serializer in the UART test path.
- Accepts a byte stream from the UART receiver and packs each group of 4 bytes, LSB first, into 32-bit words.
- Writes words into a ROWS x COLS matrix in row-major order.
- Presents the complete matrix to the compute/loopback logic with a valid/ack handshake.

Parameters:
NUM_OF_ROWS, 16, number of matrix rows
NUM_OF_COLS, 16, number of matrix columns (words per row)

Ports:
clk  input  1  clock
rstn  input  1  reset, asynchronous, active-low
rx_data  input  8  byte from UART receiver
rx_valid  input  1  rx_data valid this cycle
rx_ready  output  1  block can accept a byte (registered)
clear  input  1  synchronous abort of the current frame
matrix  output  [NUM_OF_ROWS-1:0][NUM_OF_COLS-1:0][31:0]  assembled matrix, indexed matrix[row][col]
matrix_valid  output  1  complete matrix available (level)
matrix_ack  input  1  consumer has taken the matrix
words_received  output  $clog2(NUM_OF_ROWS*NUM_OF_COLS+1)  words written in the current frame

Behaviour:
- Reset is asynchronous, active-low, on clk domain. Reset values:
  - state = IDLE
  - rx_ready = 0, matrix_valid = 0, words_received = 0
  - matrix = all zeros
  - byte index, column, row and byte buffer = 0
- States: IDLE, FILL, DONE.
- IDLE: always goes to FILL on the next edge; rx_ready <= 1. rx_ready is therefore first high in the 2nd cycle after reset release.
- FILL:
  - A byte is accepted only on an edge where rx_valid && rx_ready.
  - Byte index k (0..3): byte 0 goes to bits [7:0], byte 1 to [15:8], and so on.
  - Bytes 0-2 are held in a 24-bit buffer.
  - On byte 3: matrix[row][col] <= {rx_data, buf[23:0]}; byte index <= 0; words_received += 1.
  - Column increments after each word. At col == NUM_OF_COLS-1, col <= 0 and row += 1.
  - Order is row 0 col 0 first, col fastest.
  - On the edge accepting the final byte (row == NUM_OF_ROWS-1, col == NUM_OF_COLS-1, k == 3):
    - final word written, row/col <= 0
    - matrix_valid <= 1, rx_ready <= 0, state <= DONE
  - Latency: matrix_valid and the final word are both visible one cycle after the last byte is accepted.
- DONE:
  - matrix is held stable; rx_ready = 0, so rx_valid is ignored (backpressure, no overflow).
  - words_received holds NUM_OF_ROWS*NUM_OF_COLS.
  - matrix_ack sampled high: matrix_valid <= 0, rx_ready <= 1, words_received <= 0, state <= FILL.
  - matrix contents are retained and overwritten word by word by the next frame.
- matrix_ack in IDLE or FILL is ignored.
- clear (synchronous, any state, highest priority):
  - byte index, row, col, buffer and words_received <= 0
  - matrix_valid <= 0, rx_ready <= 1, state <= FILL
  - matrix contents are unchanged.
  - A byte presented on the same edge as clear is dropped.
  - clear and matrix_ack together act as clear.
- Asynchronous reset mid-frame returns all outputs to reset values immediately; the partial frame is discarded.
- Counters never exceed their ranges. No wrap occurs inside FILL because the last word forces DONE.

Test Plan:
1. Reset: assert rstn low mid-run -> matrix all zero, rx_ready = 0, matrix_valid = 0 immediately. Release -> rx_ready = 1 on the 2nd cycle.
2. ROWS=2, COLS=3, stream bytes 0x00..0x17 back-to-back -> matrix[0][0]=0x03020100, matrix[0][2]=0x0B0A0908, matrix[1][2]=0x17161514. matrix_valid = 1 and rx_ready = 0 one cycle after byte 0x17; words_received = 6.
3. In DONE, hold rx_valid=1, rx_data=0xAA for 10 cycles -> matrix unchanged, matrix_valid stays 1. Pulse matrix_ack -> next cycle matrix_valid = 0, rx_ready = 1. New stream 0x20.. -> matrix[0][0]=0x23222120.
4. Same stream as test 2 with random rx_valid gaps (0-5 idle cycles between bytes) -> identical final matrix and timing relative to the last accepted byte.
5. Send 5 bytes, then pulse clear together with a valid byte 0x55 -> 0x55 is dropped, words_received = 0. Following 24 bytes 0x00..0x17 reproduce the test 2 matrix exactly.
6. matrix_ack pulsed during FILL -> no effect; frame completes normally.

Source files
------------

// File: rtl/mat_rx_assembler.sv
// Receive-side matrix assembler: packs UART bytes (LSB first) into 32-bit words,
// fills a row-major NUM_OF_ROWS x NUM_OF_COLS matrix and hands it off via valid/ack.
module mat_rx_assembler #(
   parameter int NUM_OF_ROWS = 16,
   parameter int NUM_OF_COLS = 16
) (
   input  logic                                          clk,
   input  logic                                          rstn,
   input  logic [7:0]                                    rx_data,
   input  logic                                          rx_valid,
   output logic                                          rx_ready,
   input  logic                                          clear,
   output logic [NUM_OF_ROWS-1:0][NUM_OF_COLS-1:0][31:0] matrix,
   output logic                                          matrix_valid,
   input  logic                                          matrix_ack,
   output logic [$clog2(NUM_OF_ROWS*NUM_OF_COLS+1)-1:0]  words_received
);

   localparam int ROW_W = (NUM_OF_ROWS > 1) ? $clog2(NUM_OF_ROWS) : 1;
   localparam int COL_W = (NUM_OF_COLS > 1) ? $clog2(NUM_OF_COLS) : 1;
   localparam int WR_W  = $clog2(NUM_OF_ROWS*NUM_OF_COLS+1);

   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NUM_OF_ROWS-1);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(NUM_OF_COLS-1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] FILL = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]                                    state_q, state_d;
   logic                                          rx_ready_q, rx_ready_d;
   logic                                          matrix_valid_q, matrix_valid_d;
   logic [WR_W-1:0]                               words_q, words_d;
   logic [NUM_OF_ROWS-1:0][NUM_OF_COLS-1:0][31:0] matrix_q, matrix_d;
   logic [1:0]                                    byte_idx_q, byte_idx_d;
   logic [ROW_W-1:0]                              row_q, row_d;
   logic [COL_W-1:0]                              col_q, col_d;
   logic [23:0]                                   byte_buf_q, byte_buf_d;

   always_comb begin
      state_d        = state_q;
      rx_ready_d     = rx_ready_q;
      matrix_valid_d = matrix_valid_q;
      words_d        = words_q;
      matrix_d       = matrix_q;
      byte_idx_d     = byte_idx_q;
      row_d          = row_q;
      col_d          = col_q;
      byte_buf_d     = byte_buf_q;

      // clear overrides everything, including a byte or an ack on the same edge
      if (clear) begin
         byte_idx_d     = '0;
         row_d          = '0;
         col_d          = '0;
         byte_buf_d     = '0;
         words_d        = '0;
         matrix_valid_d = 1'b0;
         rx_ready_d     = 1'b1;
         state_d        = FILL;
      end else begin
         case (state_q)
            IDLE: begin
               state_d    = FILL;
               rx_ready_d = 1'b1;
            end
            FILL: begin
               if (rx_valid && rx_ready_q) begin
                  case (byte_idx_q)
                     2'd0: byte_buf_d[7:0]   = rx_data;
                     2'd1: byte_buf_d[15:8]  = rx_data;
                     2'd2: byte_buf_d[23:16] = rx_data;
                     default: ;
                  endcase
                  if (byte_idx_q == 2'd3) begin
                     matrix_d[row_q][col_q] = {rx_data, byte_buf_q};
                     byte_idx_d             = '0;
                     words_d                = words_q + WR_W'(1);
                     if (col_q == COL_LAST) begin
                        col_d = '0;
                        if (row_q == ROW_LAST) begin
                           row_d          = '0;
                           matrix_valid_d = 1'b1;
                           rx_ready_d     = 1'b0;
                           state_d        = DONE;
                        end else begin
                           row_d = row_q + ROW_W'(1);
                        end
                     end else begin
                        col_d = col_q + COL_W'(1);
                     end
                  end else begin
                     byte_idx_d = byte_idx_q + 2'd1;
                  end
               end
            end
            DONE: begin
               if (matrix_ack) begin
                  matrix_valid_d = 1'b0;
                  rx_ready_d     = 1'b1;
                  words_d        = '0;
                  state_d        = FILL;
               end
            end
            default: begin
               state_d    = IDLE;
               rx_ready_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q        <= IDLE;
         rx_ready_q     <= 1'b0;
         matrix_valid_q <= 1'b0;
         words_q        <= '0;
         matrix_q       <= '0;
         byte_idx_q     <= '0;
         row_q          <= '0;
         col_q          <= '0;
         byte_buf_q     <= '0;
      end else begin
         state_q        <= state_d;
         rx_ready_q     <= rx_ready_d;
         matrix_valid_q <= matrix_valid_d;
         words_q        <= words_d;
         matrix_q       <= matrix_d;
         byte_idx_q     <= byte_idx_d;
         row_q          <= row_d;
         col_q          <= col_d;
         byte_buf_q     <= byte_buf_d;
      end
   end

   assign rx_ready       = rx_ready_q;
   assign matrix_valid   = matrix_valid_q;
   assign words_received = words_q;
   assign matrix         = matrix_q;

endmodule

// File: tb/tb_mat_rx_assembler.sv
// Directed self-checking bench for mat_rx_assembler with a 2x3 matrix.
module tb_mat_rx_assembler;

   localparam int ROWS = 2;
   localparam int COLS = 3;
   localparam int WR_W = $clog2(ROWS*COLS+1);

   logic                         clk = 1'b0;
   logic                         rstn;
   logic [7:0]                   rx_data;
   logic                         rx_valid;
   logic                         rx_ready;
   logic                         clear;
   logic [ROWS-1:0][COLS-1:0][31:0] matrix;
   logic                         matrix_valid;
   logic                         matrix_ack;
   logic [WR_W-1:0]              words_received;

   int n_checks = 0;
   int n_fail   = 0;

   mat_rx_assembler #(.NUM_OF_ROWS(ROWS), .NUM_OF_COLS(COLS)) dut (
      .clk            (clk),
      .rstn           (rstn),
      .rx_data        (rx_data),
      .rx_valid       (rx_valid),
      .rx_ready       (rx_ready),
      .clear          (clear),
      .matrix         (matrix),
      .matrix_valid   (matrix_valid),
      .matrix_ack     (matrix_ack),
      .words_received (words_received)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // advance one edge; inputs change and outputs are sampled 1 ns after it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      rx_valid = 1'b0;
      repeat (gap) tick();
      rx_valid = 1'b1;
      rx_data  = b;
      n = 0;
      while (rx_ready !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      check("ready_wait", {31'd0, rx_ready}, 32'd1);
      tick();
      rx_valid = 1'b0;
   endtask

   // expected word at (r,c) for a frame whose first byte is base: bytes ascend by one
   task automatic check_frame(input string tag, input logic [7:0] base);
      logic [7:0] b;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            b = base + 8'((r*COLS + c)*4);
            check(tag, matrix[r][c], {b + 8'd3, b + 8'd2, b + 8'd1, b});
         end
      end
   endtask

   task automatic send_frame(input logic [7:0] base, input int max_gap);
      for (int i = 0; i < ROWS*COLS*4 - 1; i++)
         send_byte(base + 8'(i), (max_gap > 0) ? $urandom_range(0, max_gap) : 0);
      check("pre_last_valid", {31'd0, matrix_valid}, 32'd0);
      check("pre_last_words", 32'(words_received), 32'd5);
      send_byte(base + 8'(ROWS*COLS*4 - 1), (max_gap > 0) ? $urandom_range(0, max_gap) : 0);
   endtask

   initial begin
      rstn       = 1'b0;
      rx_data    = 8'h00;
      rx_valid   = 1'b0;
      clear      = 1'b0;
      matrix_ack = 1'b0;

      // reset state and ready timing after release
      tick();
      tick();
      check("rst_ready", {31'd0, rx_ready}, 32'd0);
      check("rst_valid", {31'd0, matrix_valid}, 32'd0);
      check("rst_words", 32'(words_received), 32'd0);
      check("rst_m00", matrix[0][0], 32'd0);
      rstn = 1'b1;
      #1;
      check("ready_cycle1", {31'd0, rx_ready}, 32'd0);
      tick();
      check("ready_cycle2", {31'd0, rx_ready}, 32'd1);

      // back-to-back frame
      send_frame(8'h00, 0);
      check("t2_valid", {31'd0, matrix_valid}, 32'd1);
      check("t2_ready", {31'd0, rx_ready}, 32'd0);
      check("t2_words", 32'(words_received), 32'd6);
      check("t2_m00", matrix[0][0], 32'h03020100);
      check("t2_m02", matrix[0][2], 32'h0B0A0908);
      check("t2_m12", matrix[1][2], 32'h17161514);
      check_frame("t2_frame", 8'h00);

      // backpressure in DONE
      rx_valid = 1'b1;
      rx_data  = 8'hAA;
      repeat (10) tick();
      rx_valid = 1'b0;
      check("t3_hold_valid", {31'd0, matrix_valid}, 32'd1);
      check("t3_hold_ready", {31'd0, rx_ready}, 32'd0);
      check("t3_hold_words", 32'(words_received), 32'd6);
      check_frame("t3_hold_frame", 8'h00);
      matrix_ack = 1'b1;
      tick();
      matrix_ack = 1'b0;
      check("t3_ack_valid", {31'd0, matrix_valid}, 32'd0);
      check("t3_ack_ready", {31'd0, rx_ready}, 32'd1);
      check("t3_ack_words", 32'(words_received), 32'd0);
      for (int i = 0; i < 4; i++) send_byte(8'h20 + 8'(i), 0);
      check("t3_new_m00", matrix[0][0], 32'h23222120);
      check("t3_kept_m01", matrix[0][1], 32'h07060504);
      check("t3_words1", 32'(words_received), 32'd1);
      for (int i = 4; i < 24; i++) send_byte(8'h20 + 8'(i), 0);
      check("t3_valid", {31'd0, matrix_valid}, 32'd1);
      check_frame("t3_frame", 8'h20);

      // random gaps
      matrix_ack = 1'b1;
      tick();
      matrix_ack = 1'b0;
      send_frame(8'h00, 5);
      check("t4_valid", {31'd0, matrix_valid}, 32'd1);
      check("t4_ready", {31'd0, rx_ready}, 32'd0);
      check("t4_words", 32'(words_received), 32'd6);
      check_frame("t4_frame", 8'h00);

      // clear mid-frame drops the coincident byte
      matrix_ack = 1'b1;
      tick();
      matrix_ack = 1'b0;
      for (int i = 0; i < 5; i++) send_byte(8'hE0 + 8'(i), 0);
      check("t5_words_pre", 32'(words_received), 32'd1);
      rx_valid = 1'b1;
      rx_data  = 8'h55;
      clear    = 1'b1;
      tick();
      clear    = 1'b0;
      rx_valid = 1'b0;
      check("t5_clr_words", 32'(words_received), 32'd0);
      check("t5_clr_ready", {31'd0, rx_ready}, 32'd1);
      check("t5_clr_valid", {31'd0, matrix_valid}, 32'd0);
      check("t5_clr_m00", matrix[0][0], 32'hE3E2E1E0);
      send_frame(8'h00, 0);
      check("t5_valid", {31'd0, matrix_valid}, 32'd1);
      check_frame("t5_frame", 8'h00);

      // ack during FILL is ignored
      matrix_ack = 1'b1;
      tick();
      for (int i = 0; i < 23; i++) send_byte(8'h40 + 8'(i), 0);
      check("t6_valid_mid", {31'd0, matrix_valid}, 32'd0);
      check("t6_words_mid", 32'(words_received), 32'd5);
      matrix_ack = 1'b0;
      send_byte(8'h57, 0);
      tick();
      check("t6_valid", {31'd0, matrix_valid}, 32'd1);
      check("t6_words", 32'(words_received), 32'd6);
      check_frame("t6_frame", 8'h40);

      // clear together with ack in DONE
      clear      = 1'b1;
      matrix_ack = 1'b1;
      tick();
      clear      = 1'b0;
      matrix_ack = 1'b0;
      check("clrack_valid", {31'd0, matrix_valid}, 32'd0);
      check("clrack_ready", {31'd0, rx_ready}, 32'd1);
      check("clrack_words", 32'(words_received), 32'd0);

      // asynchronous reset mid-frame
      for (int i = 0; i < 6; i++) send_byte(8'h80 + 8'(i), 0);
      check("t1_words_pre", 32'(words_received), 32'd1);
      rstn = 1'b0;
      #1;
      check("t1_async_ready", {31'd0, rx_ready}, 32'd0);
      check("t1_async_valid", {31'd0, matrix_valid}, 32'd0);
      check("t1_async_words", 32'(words_received), 32'd0);
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            check("t1_async_zero", matrix[r][c], 32'd0);
      tick();
      rstn = 1'b1;
      #1;
      check("t1_rel_ready1", {31'd0, rx_ready}, 32'd0);
      tick();
      check("t1_rel_ready2", {31'd0, rx_ready}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
